serial_adder: RTL and testbench



---
 rtl/serial_adder_if.sv | 34 +++
 rtl/serial_adder.sv | 114 +++++++++++
 tb/tb_serial_adder.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/serial_adder_if.sv
// Handshake and operand bundle for the bit-serial adder/subtractor.
// The ovf signal exists only when SERIAL_ADDER_OVF_EN is defined.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf;
`endif

  modport master (
    output start, sub, a, b, cin,
    input  busy, done, sum, cout
`ifdef SERIAL_ADDER_OVF_EN
    , input ovf
`endif
  );

  modport slave (
    input  start, sub, a, b, cin,
    output busy, done, sum, cout
`ifdef SERIAL_ADDER_OVF_EN
    , output ovf
`endif
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder step per clock, LSB first, WIDTH cycles.
// Define SERIAL_ADDER_OVF_EN to add the registered signed-overflow output ovf.
//
//   state | meaning
//   IDLE  | no result yet since reset, waiting for start
//   RUN   | shifting operands through the full adder, busy=1
//   DONE  | result held on sum/cout, done=1, start accepted directly
module serial_adder #(
  parameter int WIDTH = 8
) (
  input logic          clk,
  input logic          rst_n,
  serial_adder_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] a_sr, b_sr, res_next, sum_q;
  logic [CW-1:0]    cnt;
  logic             carry, cout_q, s, c_next;
  logic             load, finish, last;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_q;
`endif

  assign s      = a_sr[0] ^ b_sr[0] ^ carry;
  assign c_next = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
  assign last   = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          load       = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (last) begin
          finish     = 1'b1;
          state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Partial result: only WIDTH-1 bits need storing, the final bit goes straight to sum.
  generate
    if (WIDTH == 1) begin : g_w1
      assign res_next = s;
    end else begin : g_wn
      logic [WIDTH-2:0] part;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)            part <= '0;
        else if (load)         part <= '0;
        else if (state == RUN) part <= res_next[WIDTH-1:1];
      end
      assign res_next = {s, part};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q  <= 1'b0;
`endif
    end else begin
      if (load) begin
        a_sr  <= bus.a;
        b_sr  <= bus.sub ? ~bus.b : bus.b;
        carry <= bus.sub | bus.cin;
        cnt   <= '0;
      end else if (state == RUN) begin
        a_sr  <= a_sr >> 1;
        b_sr  <= b_sr >> 1;
        carry <= c_next;
        if (!last) cnt <= cnt + CW'(1);
      end
      if (finish) begin
        sum_q  <= res_next;
        cout_q <= c_next;
`ifdef SERIAL_ADDER_OVF_EN
        // carry still holds the carry into the MSB on the final step
        ovf_q  <= carry ^ c_next;
`endif
      end
    end
  end

  assign bus.busy = (state == RUN);
  assign bus.done = (state == DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign bus.ovf  = ovf_q;
`endif
endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: directed cases plus random operations,
// expected results from an integer-arithmetic model of the add/subtract rules.
module tb_serial_adder;
  localparam int W = 8;
  localparam longint unsigned MASK = (longint'(1) << W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(W)) bus();
  serial_adder #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  logic done_prev = 1'b0;
  logic busy_prev = 1'b0;
  int   run_len = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t model(logic [W-1:0] a, logic [W-1:0] b, logic cin, logic sub);
    exp_t e;
    longint unsigned full;
    longint sa, sbv, sres;
    if (sub) full = longint'(a) + (MASK - longint'(b)) + 1;
    else     full = longint'(a) + longint'(b) + longint'(cin);
    e.sum  = full[W-1:0];
    e.cout = full[W];
    sa  = longint'(a) - (a[W-1] ? (longint'(1) << W) : 0);
    sbv = longint'(b) - (b[W-1] ? (longint'(1) << W) : 0);
    sres = sub ? (sa - sbv) : (sa + sbv + longint'(cin));
    e.ovf = (sres > ((longint'(1) << (W-1)) - 1)) || (sres < -(longint'(1) << (W-1)));
    return e;
  endfunction

  // Monitor: compares every completion against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.done && !done_prev) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_done: got done=1 expected no pending operation");
        end else begin
          e = sb.pop_front();
          chk("sum", bus.sum, e.sum);
          chk("cout", bus.cout, e.cout);
`ifdef SERIAL_ADDER_OVF_EN
          chk("ovf", bus.ovf, e.ovf);
`endif
          chk("busy_cycles", run_len, W);
        end
      end
      if (bus.busy) run_len = busy_prev ? run_len + 1 : 1;
      else          run_len = 0;
      done_prev = bus.done;
      busy_prev = bus.busy;
    end
  end

  // Called at a negedge; returns at the next negedge with start dropped.
  task automatic start_op(logic [W-1:0] a, logic [W-1:0] b, logic cin, logic sub);
    bus.a = a; bus.b = b; bus.cin = cin; bus.sub = sub; bus.start = 1'b1;
    sb.push_back(model(a, b, cin, sub));
    @(negedge clk);
    bus.start = 1'b0;
    bus.a = W'($urandom); bus.b = W'($urandom);
    bus.cin = 1'($urandom); bus.sub = 1'($urandom);
  endtask

  task automatic wait_done();
    for (int i = 0; i < W + 4; i++) begin
      if (bus.done) return;
      @(negedge clk);
    end
    checks++;
    errors++;
    $display("FAIL done_timeout: got done=0 expected done=1 within %0d cycles", W + 4);
  endtask

  task automatic run_case(string name, logic [W-1:0] a, logic [W-1:0] b, logic cin,
                          logic sub, logic [W-1:0] es, logic ec);
    start_op(a, b, cin, sub);
    wait_done();
    chk({name, "_sum"}, bus.sum, es);
    chk({name, "_cout"}, bus.cout, ec);
  endtask

  initial begin
    int sp;
    bus.start = 1'b0; bus.sub = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
    #12;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_sum", bus.sum, 0);
    chk("rst_cout", bus.cout, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    start_op(8'h5A, 8'h3C, 1'b0, 1'b0);
    chk("tp1_busy", bus.busy, 1);
    wait_done();
    chk("tp1_sum", bus.sum, 8'h96);
    chk("tp1_cout", bus.cout, 0);
    repeat (5) @(negedge clk);
    chk("tp1_done_hold", bus.done, 1);
    chk("tp1_sum_hold", bus.sum, 8'h96);

    run_case("ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1);
    run_case("ff_01_cin", 8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1);
    run_case("sub_10_01", 8'h10, 8'h01, 1'b1, 1'b1, 8'h0F, 1'b1);
    run_case("sub_01_02", 8'h01, 8'h02, 1'b0, 1'b1, 8'hFF, 1'b0);

    // start during RUN is ignored, then a back-to-back start on the DONE edge
    start_op(8'h12, 8'h34, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    bus.a = 8'hFF; bus.b = 8'hFF; bus.cin = 1'b0; bus.sub = 1'b0; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done();
    chk("midrun_sum", bus.sum, 8'h46);
    start_op(8'h01, 8'h01, 1'b0, 1'b0);
    chk("b2b_busy", bus.busy, 1);
    chk("b2b_done_low", bus.done, 0);
    wait_done();
    chk("b2b_sum", bus.sum, 8'h02);

    // asynchronous reset in the middle of an operation
    start_op(8'hA5, 8'h0F, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_busy", bus.busy, 0);
    chk("async_done", bus.done, 0);
    chk("async_sum", bus.sum, 0);
    chk("async_cout", bus.cout, 0);
`ifdef SERIAL_ADDER_OVF_EN
    chk("async_ovf", bus.ovf, 0);
`endif
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    sp = 0;
    for (int i = 0; i < W + 3; i++) begin
      @(negedge clk);
      if (bus.done) sp++;
    end
    chk("no_spurious_done", sp, 0);
    run_case("post_rst", 8'h21, 8'h13, 1'b0, 1'b0, 8'h34, 1'b0);

`ifdef SERIAL_ADDER_OVF_EN
    run_case("ovf_7f_01", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0);
    chk("ovf_7f_01_ovf", bus.ovf, 1);
    run_case("ovf_80_01s", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1);
    chk("ovf_80_01s_ovf", bus.ovf, 1);
    run_case("ovf_05_03", 8'h05, 8'h03, 1'b0, 1'b0, 8'h08, 1'b0);
    chk("ovf_05_03_ovf", bus.ovf, 0);
`endif

    for (int n = 0; n < 40; n++) begin
      int gap;
      start_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
      wait_done();
      gap = $urandom_range(0, 2);
      repeat (gap) @(negedge clk);
    end

    repeat (2) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
